// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: operation encoding and index sizing.
// Imported by the element ALU and the streaming add/subtract unit.
package matrix_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Index width for a dimension of n entries; a 1-entry dimension still gets a 1-bit port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Combinational element add/subtract with optional saturation to the DW-bit range.
// Shared with the matrix multiplier accumulator, so it carries no state.
module matrix_elem_alu
  import matrix_pkg::*;
#(
  parameter int DW  = 3,
  parameter int SAT = 0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          op,
  output logic [DW:0]   c,
  output logic          ovf
);

  logic [DW:0] sum;
  logic [DW:0] diff;
  logic        borrow;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign borrow = (a < b);

  always_comb begin
    c   = sum;
    ovf = sum[DW];
    if (op == OP_SUB) begin
      c   = diff;
      ovf = borrow;
    end
    // Clamp keeps ovf as the record that the true result left the DW-bit range.
    if ((SAT != 0) && ovf) begin
      c = (op == OP_SUB) ? '0 : {1'b0, {DW{1'b1}}};
    end
  end

endmodule

// File: rtl/matrix_addsub_stream.sv
// Streaming ROWS x COLS matrix add/subtract: one element pair in, one result out per beat.
// Single output register; the input stalls whenever that register is full and not draining.
module matrix_addsub_stream
  import matrix_pkg::*;
#(
  parameter int DW   = 3,
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int SAT  = 0,
  localparam int RW  = idx_width(ROWS),
  localparam int CW  = idx_width(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW:0]   out_c,
  output logic          out_ovf,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  output logic          out_ovf_any
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_reg;
  logic [RW-1:0] row_next;
  logic [CW-1:0] col_reg;
  logic [CW-1:0] col_next;
  logic          op_reg;
  logic          sticky_reg;

  logic          in_fire;
  logic          first_elem;
  logic          last_elem;
  logic          op_eff;
  logic [DW:0]   alu_c;
  logic          alu_ovf;

  assign in_ready   = !out_valid || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign first_elem = (row_reg == '0) && (col_reg == '0);
  assign last_elem  = (row_reg == ROW_MAX) && (col_reg == COL_MAX);
  // The first element of a matrix cannot wait for the latch, so it uses in_op directly.
  assign op_eff     = first_elem ? in_op : op_reg;

  matrix_elem_alu #(
    .DW  (DW),
    .SAT (SAT)
  ) u_alu (
    .a   (in_a),
    .b   (in_b),
    .op  (op_eff),
    .c   (alu_c),
    .ovf (alu_ovf)
  );

  always_comb begin
    row_next = row_reg;
    col_next = col_reg + CW'(1);
    if (col_reg == COL_MAX) begin
      col_next = '0;
      row_next = (row_reg == ROW_MAX) ? '0 : row_reg + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg     <= '0;
      col_reg     <= '0;
      op_reg      <= OP_ADD;
      sticky_reg  <= 1'b0;
      out_valid   <= 1'b0;
      out_c       <= '0;
      out_ovf     <= 1'b0;
      out_row     <= '0;
      out_col     <= '0;
      out_last    <= 1'b0;
      out_ovf_any <= 1'b0;
    end else begin
      if (in_fire) begin
        row_reg     <= row_next;
        col_reg     <= col_next;
        if (first_elem) begin
          op_reg <= in_op;
        end
        // Sticky restarts with each matrix; the summary rides on the last element only.
        sticky_reg  <= last_elem ? 1'b0 : (sticky_reg | alu_ovf);
        out_valid   <= 1'b1;
        out_c       <= alu_c;
        out_ovf     <= alu_ovf;
        out_row     <= row_reg;
        out_col     <= col_reg;
        out_last    <= last_elem;
        out_ovf_any <= last_elem ? (sticky_reg | alu_ovf) : 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_addsub_stream.sv
// Self-checking bench: 2x2 full-width, 2x2 saturating and 1x1 instances share one input stream
// and are compared against an arithmetic reference model of the matrix element sequence.
module tb_matrix_addsub_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_op = 1'b0;
  logic       out_ready = 1'b1;
  logic [2:0] in_a = '0;
  logic [2:0] in_b = '0;

  logic       r0, r1, r2;
  logic       o0_valid, o1_valid, o2_valid;
  logic [3:0] o0_c, o1_c, o2_c;
  logic       o0_ovf, o1_ovf, o2_ovf;
  logic [0:0] o0_row, o1_row, o2_row;
  logic [0:0] o0_col, o1_col, o2_col;
  logic       o0_last, o1_last, o2_last;
  logic       o0_any, o1_any, o2_any;

  matrix_addsub_stream #(.DW(3), .ROWS(2), .COLS(2), .SAT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(o0_valid), .out_ready(out_ready), .out_c(o0_c), .out_ovf(o0_ovf),
    .out_row(o0_row), .out_col(o0_col), .out_last(o0_last), .out_ovf_any(o0_any));

  matrix_addsub_stream #(.DW(3), .ROWS(2), .COLS(2), .SAT(1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(o1_valid), .out_ready(out_ready), .out_c(o1_c), .out_ovf(o1_ovf),
    .out_row(o1_row), .out_col(o1_col), .out_last(o1_last), .out_ovf_any(o1_any));

  matrix_addsub_stream #(.DW(3), .ROWS(1), .COLS(1), .SAT(0)) u_dut_1x1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .out_valid(o2_valid), .out_ready(out_ready), .out_c(o2_c), .out_ovf(o2_ovf),
    .out_row(o2_row), .out_col(o2_col), .out_last(o2_last), .out_ovf_any(o2_any));

  always #5 clk = ~clk;

  wire [9:0] obs0 = {o0_valid, o0_c, o0_ovf, o0_row, o0_col, o0_last, o0_any};
  wire [9:0] obs1 = {o1_valid, o1_c, o1_ovf, o1_row, o1_col, o1_last, o1_any};
  wire [9:0] obs2 = {o2_valid, o2_c, o2_ovf, o2_row, o2_col, o2_last, o2_any};

  typedef struct packed {
    logic [3:0] c0, c1, c2;
    logic       ovf, ovf2, row, col, last, any;
  } exp_t;

  int   n_tests = 0;
  int   n_fail = 0;
  int   m_idx = 0;
  logic m_op = 1'b0;
  logic m_sticky = 1'b0;

  // {ovf, c} of one element computed with plain integer arithmetic.
  function automatic logic [4:0] calc(input logic [2:0] a, input logic [2:0] b,
                                      input logic op, input bit sat);
    int   r;
    logic ovf;
    if (op == 1'b0) begin
      r   = int'(a) + int'(b);
      ovf = (r > 7);
      if (sat && ovf) r = 7;
    end else begin
      r   = int'(a) - int'(b);
      ovf = (r < 0);
      if (r < 0) r = sat ? 0 : r + 16;
    end
    return {ovf, 4'(r)};
  endfunction

  // Advance the reference by one accepted element pair (element index within the 2x2 matrix).
  function automatic exp_t model_step(input logic [2:0] a, input logic [2:0] b, input logic op_in);
    exp_t       e;
    logic [4:0] x0, x1, x2;
    if (m_idx == 0) m_op = op_in;
    x0 = calc(a, b, m_op, 1'b0);
    x1 = calc(a, b, m_op, 1'b1);
    x2 = calc(a, b, op_in, 1'b0);
    e.c0 = x0[3:0]; e.c1 = x1[3:0]; e.ovf = x0[4];
    e.c2 = x2[3:0]; e.ovf2 = x2[4];
    e.row  = (m_idx >= 2);
    e.col  = ((m_idx % 2) == 1);
    e.last = (m_idx == 3);
    e.any  = e.last && (m_sticky || e.ovf);
    m_sticky = e.last ? 1'b0 : (m_sticky | e.ovf);
    m_idx = (m_idx + 1) % 4;
    return e;
  endfunction

  function automatic logic [9:0] exp0(input exp_t e);
    return {1'b1, e.c0, e.ovf, e.row, e.col, e.last, e.any};
  endfunction
  function automatic logic [9:0] exp1(input exp_t e);
    return {1'b1, e.c1, e.ovf, e.row, e.col, e.last, e.any};
  endfunction
  function automatic logic [9:0] exp2(input exp_t e);
    return {1'b1, e.c2, e.ovf2, 1'b0, 1'b0, 1'b1, e.ovf2};
  endfunction

  task automatic put(input logic [2:0] a, input logic [2:0] b, input logic op);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({obs0, obs1, obs2} !== 30'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h %h %h want 0", obs0, obs1, obs2);
    end
    n_tests++;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", r0); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_add();
    logic [2:0] av[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [3:0] cv[4] = '{4'd2, 4'd3, 4'd4, 4'd5};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      put(av[i], 3'd1, 1'b0);
      e = model_step(av[i], 3'd1, 1'b0);
      @(posedge clk); #1;
      n_tests++;
      if (obs0 !== exp0(e)) begin n_fail++; $display("FAIL add[%0d]: got %h want %h", i, obs0, exp0(e)); end
      n_tests++;
      if (obs1 !== exp1(e)) begin n_fail++; $display("FAIL add_sat[%0d]: got %h want %h", i, obs1, exp1(e)); end
      n_tests++;
      if (obs2 !== exp2(e)) begin n_fail++; $display("FAIL add_1x1[%0d]: got %h want %h", i, obs2, exp2(e)); end
      n_tests++;
      if (o0_c !== cv[i]) begin n_fail++; $display("FAIL add_c[%0d]: got %0d want %0d", i, o0_c, cv[i]); end
      $display("[TB] add beat %0d c=%0d last=%b any=%b", i, o0_c, o0_last, o0_any);
    end
    idle();
  endtask

  task automatic test_add_carry();
    logic [2:0] av[4] = '{3'd0, 3'd3, 3'd5, 3'd7};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      put(av[i], av[i], 1'b0);
      e = model_step(av[i], av[i], 1'b0);
      @(posedge clk); #1;
      n_tests++;
      if (obs0 !== exp0(e)) begin n_fail++; $display("FAIL carry[%0d]: got %h want %h", i, obs0, exp0(e)); end
      n_tests++;
      if (obs1 !== exp1(e)) begin n_fail++; $display("FAIL carry_sat[%0d]: got %h want %h", i, obs1, exp1(e)); end
      n_tests++;
      if (obs2 !== exp2(e)) begin n_fail++; $display("FAIL carry_1x1[%0d]: got %h want %h", i, obs2, exp2(e)); end
      $display("[TB] carry beat %0d c=%0d sat_c=%0d ovf=%b any=%b", i, o0_c, o1_c, o0_ovf, o0_any);
    end
    n_tests++;
    if ({o0_c, o1_c, o0_ovf, o0_last, o0_any} !== {4'd14, 4'd7, 1'b1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL carry_7p7: got c=%0d sat=%0d ovf=%b last=%b any=%b want 14 7 1 1 1",
                         o0_c, o1_c, o0_ovf, o0_last, o0_any);
    end
    idle();
  endtask

  task automatic test_sub();
    logic [2:0] av[4] = '{3'd5, 3'd2, 3'd7, 3'd0};
    logic [2:0] bv[4] = '{3'd3, 3'd4, 3'd7, 3'd1};
    logic [3:0] cv[4] = '{4'd2, 4'd14, 4'd0, 4'd15};
    logic [3:0] sv[4] = '{4'd2, 4'd0, 4'd0, 4'd0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      put(av[i], bv[i], 1'b1);
      e = model_step(av[i], bv[i], 1'b1);
      @(posedge clk); #1;
      n_tests++;
      if (obs0 !== exp0(e)) begin n_fail++; $display("FAIL sub[%0d]: got %h want %h", i, obs0, exp0(e)); end
      n_tests++;
      if (obs2 !== exp2(e)) begin n_fail++; $display("FAIL sub_1x1[%0d]: got %h want %h", i, obs2, exp2(e)); end
      n_tests++;
      if ({o0_c, o1_c} !== {cv[i], sv[i]}) begin
        n_fail++; $display("FAIL sub_c[%0d]: got %0d/%0d want %0d/%0d", i, o0_c, o1_c, cv[i], sv[i]);
      end
      $display("[TB] sub beat %0d c=%0d sat_c=%0d ovf=%b", i, o0_c, o1_c, o0_ovf);
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [2:0] av[4] = '{3'd5, 3'd2, 3'd7, 3'd0};
    logic [2:0] bv[4] = '{3'd3, 3'd4, 3'd7, 3'd1};
    exp_t e0, e;
    put(av[0], bv[0], 1'b1);
    e0 = model_step(av[0], bv[0], 1'b1);
    @(posedge clk); #1;
    n_tests++;
    if (obs0 !== exp0(e0)) begin n_fail++; $display("FAIL bp_beat0: got %h want %h", obs0, exp0(e0)); end
    put(av[1], bv[1], 1'b1);
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", r0); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (obs0 !== exp0(e0) || o0_c !== 4'd2) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", k, obs0, exp0(e0));
      end
      $display("[TB] stall cycle %0d c=%0d in_ready=%b", k, o0_c, r0);
    end
    @(negedge clk) out_ready = 1'b1;
    e = model_step(av[1], bv[1], 1'b1);
    @(posedge clk); #1;
    n_tests++;
    if (obs0 !== exp0(e)) begin n_fail++; $display("FAIL bp_beat1: got %h want %h", obs0, exp0(e)); end
    for (int i = 2; i < 4; i++) begin
      put(av[i], bv[i], 1'b1);
      e = model_step(av[i], bv[i], 1'b1);
      @(posedge clk); #1;
      n_tests++;
      if (obs1 !== exp1(e)) begin n_fail++; $display("FAIL bp_beat%0d: got %h want %h", i, obs1, exp1(e)); end
      $display("[TB] bp beat %0d c=%0d", i, o0_c);
    end
    idle();
  endtask

  task automatic test_op_latch();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a = 3'($urandom_range(0, 7));
      logic [2:0] b = 3'($urandom_range(0, 7));
      logic       op = (i == 0) ? 1'b0 : 1'b1;
      put(a, b, op);
      e = model_step(a, b, op);
      @(posedge clk); #1;
      n_tests++;
      if (obs0 !== exp0(e)) begin n_fail++; $display("FAIL op_latch[%0d]: got %h want %h", i, obs0, exp0(e)); end
      n_tests++;
      if (obs2 !== exp2(e)) begin n_fail++; $display("FAIL op_latch_1x1[%0d]: got %h want %h", i, obs2, exp2(e)); end
      if (i < 4) begin
        n_tests++;
        if (o0_c !== 4'(int'(a) + int'(b))) begin
          n_fail++; $display("FAIL op_latch_sum[%0d]: got %0d want %0d", i, o0_c, int'(a) + int'(b));
        end
      end
      $display("[TB] op_latch beat %0d a=%0d b=%0d op=%b c=%0d", i, a, b, op, o0_c);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      put(3'd6, 3'd3, 1'b0);
      e = model_step(3'd6, 3'd3, 1'b0);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({obs0, obs1, obs2} !== 30'd0) begin
      n_fail++; $display("FAIL mid_reset: got %h %h %h want 0", obs0, obs1, obs2);
    end
    m_idx = 0; m_sticky = 1'b0; m_op = 1'b0;
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] a = 3'($urandom_range(0, 7));
      logic [2:0] b = 3'($urandom_range(0, 7));
      put(a, b, 1'b1);
      e = model_step(a, b, 1'b1);
      @(posedge clk); #1;
      n_tests++;
      if (obs0 !== exp0(e)) begin n_fail++; $display("FAIL after_reset[%0d]: got %h want %h", i, obs0, exp0(e)); end
      $display("[TB] after reset beat %0d row=%0d col=%0d c=%0d", i, o0_row, o0_col, o0_c);
    end
    idle();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    bit   fired;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!in_valid && cyc < 380 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_a = 3'($urandom_range(0, 7));
        in_b = 3'($urandom_range(0, 7));
        in_op = 1'($urandom_range(0, 1));
      end
      if (cyc >= 380) in_valid = 1'b0;
      out_ready = (cyc >= 380) || ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if ({r0, r1, r2} !== {3{!o0_valid || out_ready}}) begin
        n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b%b%b valid=%b ready=%b", cyc, r0, r1, r2, o0_valid, out_ready);
      end
      if (o0_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra[%0d]: got %h want nothing", cyc, obs0);
        end else begin
          e = q.pop_front();
          if (obs0 !== exp0(e) || obs1 !== exp1(e) || obs2 !== exp2(e)) begin
            n_fail++; $display("FAIL rnd_out[%0d]: got %h %h %h want %h %h %h",
                               cyc, obs0, obs1, obs2, exp0(e), exp1(e), exp2(e));
          end
          $display("[TB] rnd out cyc %0d c=%0d ovf=%b last=%b any=%b", cyc, o0_c, o0_ovf, o0_last, o0_any);
        end
      end
      fired = in_valid && r0;
      if (fired) q.push_back(model_step(in_a, in_b, in_op));
      @(posedge clk); #1;
      if (fired) in_valid = 1'b0;
    end
    n_tests++;
    if (q.size() != 0 || o0_valid !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain: got %0d pending valid=%b want 0 0", q.size(), o0_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_add_carry();
    test_sub();
    test_backpressure();
    test_op_latch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
